// File: rtl/digit_scan_ctrl_pkg.sv
// digit_scan_ctrl_pkg: shared FSM state encodings and the 100 MHz default slot length
package digit_scan_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
  localparam int DEF_DIV = 100000;
endpackage

// File: rtl/digit_scan_ctrl_tick_gen.sv
// scan_tick_gen: slot prescaler counting 0..DIV-1, tick on the wrap cycle
module scan_tick_gen
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    tick,
  output logic [$clog2(DIV)-1:0] cnt
);
  localparam int CNT_W = $clog2(DIV);
  logic [CNT_W-1:0] r_cnt;
  assign tick = en && r_cnt == CNT_W'(DIV - 1);
  assign cnt  = r_cnt;
  always_ff @(posedge clk)
    if (!rst || !en) r_cnt <= '0;
    else r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed display digit scanner; define SCAN_BLANK_EN for a blank gap at each slot start
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = DEF_DIV,
  parameter int BLANK  = 1000,
  localparam int IDX_W = DIGITS > 2 ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [IDX_W-1:0]  dig_idx,
  output logic [DIGITS-1:0] dig_sel_n,
  output logic              blank,
  output logic              frame_start
);
  localparam int CNT_W = $clog2(DIV);
  localparam state_t GAP =
`ifdef SCAN_BLANK_EN
    ST_BLANK;
`else
    ST_SHOW;
`endif
  if (DIGITS < 2 || DIGITS > 8 || DIV < 4 || BLANK < 1 || BLANK > DIV - 2) begin : g_bad_cfg
    $fatal(1, "digit_scan_ctrl: illegal DIGITS/DIV/BLANK combination");
  end
  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [DIGITS-1:0] r_sel_n, w_sel_n_nxt;
  logic              r_blank, w_blank_nxt, r_frame, w_frame_nxt, w_tick, w_run;
  logic [CNT_W-1:0]  w_cnt;
  assign w_run = en && r_state != ST_IDLE;
  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (w_run),
    .tick(w_tick),
    .cnt (w_cnt)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_sel_n <= '1;
      r_blank <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sel_n <= w_sel_n_nxt;
      r_blank <= w_blank_nxt;
      r_frame <= w_frame_nxt;
    end
  // w_tick already carries en, so a tick on the cycle en falls is dropped
  always_comb begin
    w_idx_nxt   = w_tick ? (r_idx == IDX_W'(DIGITS - 1) ? '0 : r_idx + 1'b1) : r_idx;
    w_state_nxt = ST_IDLE;
    if (en)
      case (r_state)
        ST_IDLE:  w_state_nxt = GAP;
        ST_BLANK: w_state_nxt = w_cnt == CNT_W'(BLANK - 1) ? ST_SHOW : ST_BLANK;
        ST_SHOW:  w_state_nxt = w_tick ? GAP : ST_SHOW;
        default:  w_state_nxt = ST_IDLE;
      endcase
  end
  // outputs are decoded from the next state so they change on the same edge as it
  always_comb begin
    w_sel_n_nxt = w_state_nxt == ST_SHOW ? ~(DIGITS'(1) << w_idx_nxt) : '1;
    w_blank_nxt = w_state_nxt != ST_SHOW;
    w_frame_nxt = w_tick && r_idx == IDX_W'(DIGITS - 1);
  end
  assign dig_idx     = r_idx;
  assign dig_sel_n   = r_sel_n;
  assign blank       = r_blank;
  assign frame_start = r_frame;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed checks of the digit scanner at DIV=10, BLANK=2
module tb_digit_scan_ctrl;
  localparam int B =
`ifdef SCAN_BLANK_EN
    2;
`else
    0;
`endif
  localparam bit BL = B > 0;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [1:0] dig_idx, idx3;
  logic [3:0] dig_sel_n;
  logic [2:0] sel3;
  logic       blank, frame_start, blank3, fs3;
  int total = 0, bad = 0, cyc = 0, fcnt = 0;
  always #5 clk = ~clk;
  digit_scan_ctrl #(.DIGITS(4), .DIV(10), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .dig_idx(dig_idx), .dig_sel_n(dig_sel_n), .blank(blank), .frame_start(frame_start)
  );
  digit_scan_ctrl #(.DIGITS(3), .DIV(10), .BLANK(2)) dut3 (
    .clk(clk), .rst(rst), .en(en),
    .dig_idx(idx3), .dig_sel_n(sel3), .blank(blank3), .frame_start(fs3)
  );
  typedef struct {
    int         cyc;
    logic [1:0] idx;
    logic [3:0] sel;
    logic       bl;
    logic       fs;
  } vec_t;
  vec_t vt[10];
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    step();
    step();
    rst = 1'b1;
    en  = 1'b1;
    cyc = 0;
  endtask
  task automatic cmp(input string nm, input int c, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b (idx,sel_n,blank,frame_start)", nm, c, got, want);
    end
  endtask
  task automatic chk(input int c);
    int k, pos;
    logic [1:0] ei;
    logic eb;
    k   = c > 0 ? (c - 1) / 10 : 0;
    pos = c > 0 ? (c - 1) % 10 : 0;
    ei  = 2'(k % 4);
    eb  = c == 0 || pos < B;
    cmp("scan", c, {dig_idx, dig_sel_n, blank, frame_start},
        {ei, eb ? 4'hF : ~(4'b1 << ei), eb, c > 1 && pos == 0 && ei == 2'd0});
    cmp("onehot", c, {7'd0, $countones(~dig_sel_n) <= 1}, 8'd1);
  endtask
  task automatic chk3(input int c);
    int k, pos;
    logic [1:0] ei;
    logic eb;
    k   = (c - 1) / 10;
    pos = (c - 1) % 10;
    ei  = 2'(k % 3);
    eb  = pos < B;
    cmp("scan3", c, {1'b0, idx3, sel3, blank3, fs3},
        {1'b0, ei, eb ? 3'h7 : ~(3'b1 << ei), eb, pos == 0 && ei == 2'd0});
  endtask
  initial begin
    vt = '{
      '{0,  2'd0, 4'hF,              1'b1, 1'b0},
      '{1,  2'd0, BL ? 4'hF : 4'hE, BL,   1'b0},
      '{2,  2'd0, BL ? 4'hF : 4'hE, BL,   1'b0},
      '{3,  2'd0, 4'hE,              1'b0, 1'b0},
      '{10, 2'd0, 4'hE,              1'b0, 1'b0},
      '{11, 2'd1, BL ? 4'hF : 4'hD, BL,   1'b0},
      '{13, 2'd1, 4'hD,              1'b0, 1'b0},
      '{40, 2'd3, 4'h7,              1'b0, 1'b0},
      '{41, 2'd0, BL ? 4'hF : 4'hE, BL,   1'b1},
      '{42, 2'd0, BL ? 4'hF : 4'hE, BL,   1'b0}
    };
    do_reset();
    foreach (vt[i]) begin
      run_to(vt[i].cyc);
      cmp($sformatf("vec%0d", i), cyc, {dig_idx, dig_sel_n, blank, frame_start},
          {vt[i].idx, vt[i].sel, vt[i].bl, vt[i].fs});
    end
    for (int c = 43; c <= 450; c++) begin
      run_to(c);
      chk(c);
      chk3(c);
      fcnt += int'(frame_start);
    end
    cmp("frames", cyc, 8'(fcnt), 8'd10);
    do_reset();
    run_to(25);
    en = 1'b0;
    for (int c = 26; c <= 30; c++) begin
      run_to(c);
      cmp("en_off", c, {dig_idx, dig_sel_n, blank, frame_start}, {2'd2, 4'hF, 1'b1, 1'b0});
    end
    en = 1'b1;
    for (int c = 31; c <= 41; c++) begin
      run_to(c);
      cmp("resume", c, {dig_idx, dig_sel_n, blank, frame_start},
          c == 41 ? {2'd3, BL ? 4'hF : 4'h7, BL, 1'b0}
                  : {2'd2, c - 31 < B ? 4'hF : 4'hB, c - 31 < B, 1'b0});
    end
    do_reset();
    run_to(40);
    cmp("tick_pre", cyc, {dig_idx, dig_sel_n, blank, frame_start}, {2'd3, 4'h7, 1'b0, 1'b0});
    en = 1'b0;
    for (int c = 41; c <= 45; c++) begin
      run_to(c);
      cmp("tick_drop", c, {dig_idx, dig_sel_n, blank, frame_start}, {2'd3, 4'hF, 1'b1, 1'b0});
    end
    en = 1'b1;
    run_to(55);
    cmp("tick_resume", cyc, {dig_idx, dig_sel_n, blank, frame_start}, {2'd3, 4'h7, 1'b0, 1'b0});
    run_to(56);
    cmp("tick_wrap", cyc, {dig_idx, dig_sel_n, blank, frame_start},
        {2'd0, BL ? 4'hF : 4'hE, BL, 1'b1});
    do_reset();
    run_to(15);
    cmp("pre_rst", cyc, {dig_idx, dig_sel_n, blank, frame_start}, {2'd1, 4'hD, 1'b0, 1'b0});
    rst = 1'b0;
    run_to(16);
    cmp("rst_mid", cyc, {dig_idx, dig_sel_n, blank, frame_start}, {2'd0, 4'hF, 1'b1, 1'b0});
    rst = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      run_to(c);
      chk(c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
